uart_receiver_param: RTL and testbench
======================================

Name: uart_receiver_param

Overview:
Parametrised UART receive engine for the UART subsystem.
- Configurable data width, parity mode and stop-bit count.
- Majority-vote (3-sample) bit decisions and false-start rejection.
- Parity, framing and overrun error reporting.
- One-entry output buffer with valid/ready handshake, so downstream logic may stall without losing a completed frame.

Parameters:
SYS_PERIOD, 100_000_000, system clock frequency in Hz
BPS, 115_200, baud rate; BIT_PERIOD = SYS_PERIOD/BPS (integer division, must be >= 8); HALF = BIT_PERIOD/2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, legal 1 or 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
uart_rxd  input  1  serial line, asynchronous, idle high
rx_data  output  DATA_BITS  received word, LSB first on the line; valid while rx_valid=1
rx_valid  output  1  buffer holds an unconsumed frame
rx_ready  input  1  consumer accepts on the cycle where rx_valid && rx_ready
parity_err  output  1  parity mismatch for the frame in rx_data; qualified by rx_valid; 0 when PARITY_MODE=0
frame_err  output  1  at least one stop bit voted 0 for the frame in rx_data; qualified by rx_valid
overrun_err  output  1  one-cycle pulse: a completed frame was dropped because the buffer was full

Behaviour:
Reset (async assert):
- All outputs 0, rx_data 0, FSM to IDLE, counters 0.
- Synchroniser flops reset to 1 (idle line) so release does not fake a start edge.

Input path:
- uart_rxd passes through a 2-flop synchroniser, giving rxd_s.
- Falling-edge detect: rxd_s == 0 and the previous rxd_s == 1.

Bit counter:
- cnt is $clog2(BIT_PERIOD) bits wide, counts 0..BIT_PERIOD-1 and wraps to 0.
- It is held at 0 in IDLE.
- Samples of rxd_s are taken at cnt == HALF-1, HALF and HALF+1.
- Bit value = majority of the 3 samples, decided at cnt == HALF+1.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a falling edge go to START with cnt=0.
- START: if the decided value is 1, the start is false: return to IDLE, no flags. Otherwise go to DATA when cnt == BIT_PERIOD-1.
- DATA: bit index 0..DATA_BITS-1, shifted in LSB first. After the last bit go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: expected bit = XOR of the data bits, inverted for odd parity. perr = decided value != expected.
- STOP: STOP_BITS bits. ferr is set if any decided stop value is 0.
  - On the decision of the last stop bit (cnt == HALF+1), deliver the frame and go to IDLE immediately.
  - The remaining half stop bit is not waited for, so back-to-back frames resynchronise on the next start edge.
  - Line held low (break): frame delivered with frame_err=1. No new start is accepted until rxd_s has returned high, because the edge detector requires a 1 to 0 transition.

Delivery (on the cycle after the last stop decision):
- Buffer empty, or accepted on this same cycle (rx_valid && rx_ready): load rx_data, parity_err and frame_err; rx_valid=1.
- Buffer full and not accepted this cycle: drop the new frame; pulse overrun_err for 1 cycle; the old contents and rx_valid are unchanged.
- Accept with no new delivery: rx_valid goes to 0 next cycle. rx_data and the error flags hold their last values.

Timing and mode rules:
- Latency: rx_valid rises 1 clock after cnt == HALF+1 of the last stop bit.
- Parity and stop handling follow the parameters only; there is no runtime mode change.
- rst_n asserted mid-frame aborts immediately. After release the block waits for a fresh falling edge; a partial frame is never delivered.

Test Plan:
(all with SYS_PERIOD=16, BPS=1, so BIT_PERIOD=16, HALF=8)
- 8N1, send 0xA5, rx_ready=1 -> rx_valid pulses 1 cycle; rx_data=0xA5; parity_err=0; frame_err=0.
- PARITY_MODE=2, send 0x03 with parity bit 1 (wrong) -> rx_data=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0. PARITY_MODE=1, 0x03 with parity 1 -> parity_err=0.
- 8N1, send 0x5A with stop bit forced 0 -> rx_data=0x5A, frame_err=1. Line then held low 40 cycles -> no further frame until the line goes high and a new edge arrives.
- Start glitch: line low 4 cycles then high -> FSM returns to IDLE; no rx_valid, no flags. A following valid 0x3C frame is received correctly.
- Single-cycle glitch inside data bit 2 (sample at cnt=HALF only) of 0x00 -> majority rejects it, rx_data=0x00.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once at the second frame end. Then rx_ready=1 on the exact completion cycle of a third frame 0x33 -> 0x11 consumed, 0x33 loaded, rx_valid stays 1, no overrun.
- DATA_BITS=9, STOP_BITS=2: send 0x1FF, then assert rst_n low mid-data -> all outputs 0 and no delivery; after release a 0x155 frame is received correctly.

Source files
------------

// File: rtl/uart_receiver_param.sv
// UART receive engine: parametrised width/parity/stop bits,
// 3-sample majority decisions, one-entry output buffer.
module uart_receiver_param #(
  parameter int SYS_PERIOD  = 100_000_000,
  parameter int BPS         = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int BIT_PERIOD = SYS_PERIOD / BPS;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int CW         = $clog2(BIT_PERIOD);
  localparam int IW         = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD    = (PARITY_MODE == 1);
  localparam logic          HAS_P  = (PARITY_MODE != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 meta_q, rxd_s_q, rxd_prev_q;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;

  logic fall, maj, at_dec, at_end, exp_par, done;

  assign fall    = ~rxd_s_q & rxd_prev_q;
  assign maj     = (s0_q & s1_q) | (s0_q & rxd_s_q) | (s1_q & rxd_s_q);
  assign at_dec  = (cnt_q == C_DEC);
  assign at_end  = (cnt_q == C_LAST);
  assign exp_par = (^shift_q) ^ ODD;

  // Synchronise the line; idle-high reset avoids a fake start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q     <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      meta_q     <= uart_rxd;
      rxd_s_q    <= meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  // Frame FSM, bit timing, sampling and output buffer next state.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    data_d  = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    ovr_d   = 1'b0;
    done    = 1'b0;

    cnt_d = (state_q == S_IDLE || at_end) ? '0 : cnt_q + CW'(1);

    if (cnt_q == C_S0) s0_d = rxd_s_q;
    if (cnt_q == C_S1) s1_d = rxd_s_q;

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (at_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (at_dec) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_end) begin
          if (bit_q == I_LAST) begin
            state_d = HAS_P ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + IW'(1);
          end
        end
      end
      S_PARITY: begin
        if (at_dec) perr_d = maj ^ exp_par;
        if (at_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_dec) begin
          if (!maj) ferr_d = 1'b1;
          if (stop_q == S_LAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else if (at_end) begin
          stop_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        pe_d    = HAS_P & perr_q;
        fe_d    = ferr_q | ~maj;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = pe_q;
  assign frame_err   = fe_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_receiver_param.sv
// Bench for uart_receiver_param: four configurations (8N1, 8E1,
// 8O1, 9N2) driven by directed and random frames.
module tb_uart_receiver_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd [4];
  logic       rdy [4];
  logic [7:0] d8  [3];
  logic [8:0] d9;
  logic       rv  [4];
  logic       pe  [4];
  logic       fe  [4];
  logic       ov  [4];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int fstart = 0;
  int vcnt [4] = '{default: 0};
  int ocnt [4] = '{default: 0};
  int rise [4] = '{default: -1};
  logic rvp [4] = '{default: 1'b0};

  uart_receiver_param #(.SYS_PERIOD(16), .BPS(1), .DATA_BITS(8),
    .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[0]), .rx_data(d8[0]),
    .rx_valid(rv[0]), .rx_ready(rdy[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun_err(ov[0]));

  uart_receiver_param #(.SYS_PERIOD(16), .BPS(1), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[1]), .rx_data(d8[1]),
    .rx_valid(rv[1]), .rx_ready(rdy[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun_err(ov[1]));

  uart_receiver_param #(.SYS_PERIOD(16), .BPS(1), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[2]), .rx_data(d8[2]),
    .rx_valid(rv[2]), .rx_ready(rdy[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun_err(ov[2]));

  uart_receiver_param #(.SYS_PERIOD(16), .BPS(1), .DATA_BITS(9),
    .PARITY_MODE(0), .STOP_BITS(2)) u_9n2 (
    .clk(clk), .rst_n(rst_n), .uart_rxd(rxd[3]), .rx_data(d9),
    .rx_valid(rv[3]), .rx_ready(rdy[3]), .parity_err(pe[3]),
    .frame_err(fe[3]), .overrun_err(ov[3]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe valid/overrun activity and the cycle valid rises.
  always @(negedge clk) begin
    for (int u = 0; u < 4; u++) begin
      if (rv[u]) vcnt[u]++;
      if (ov[u]) ocnt[u]++;
      if (rv[u] && !rvp[u]) rise[u] = cyc;
      rvp[u] = rv[u];
    end
  end

  function automatic int nd_of(int u);
    return (u == 3) ? 9 : 8;
  endfunction

  function automatic int pm_of(int u);
    case (u)
      1:       return 2;
      2:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int ns_of(int u);
    return (u == 3) ? 2 : 1;
  endfunction

  function automatic logic [8:0] mask_of(int u, logic [8:0] d);
    return (u == 3) ? d : {1'b0, d[7:0]};
  endfunction

  function automatic logic [8:0] data_of(int u);
    return (u == 3) ? d9 : {1'b0, d8[u]};
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_pb(int u, logic [8:0] d);
    int ones;
    ones = $countones(mask_of(u, d));
    if (pm_of(u) == 2) return ones[0];
    return ~ones[0];
  endfunction

  function automatic logic model_pe(int u, logic [8:0] d, logic pb);
    if (pm_of(u) == 0) return 1'b0;
    return pb != good_pb(u, d);
  endfunction

  function automatic logic model_fe(int u, logic [1:0] st);
    logic f;
    f = 1'b0;
    for (int i = 0; i < ns_of(u); i++) if (!st[i]) f = 1'b1;
    return f;
  endfunction

  // Cycle in which valid must first be seen, from frame geometry.
  function automatic int exp_rise(int u);
    int k;
    k = nd_of(u) + ((pm_of(u) != 0) ? 1 : 0) + ns_of(u);
    return fstart + 13 + 16 * k;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one frame, 16 cycles per bit; optional one-cycle glitch,
  // one-cycle ready pulse and mid-frame reset at drive cycle offsets.
  task automatic send(input int u, input logic [8:0] d, input logic pb,
                      input logic [1:0] st, input int glitch,
                      input int rdy_at, input int abort_at,
                      input logic idle_after);
    logic b [$];
    b.push_back(1'b0);
    for (int i = 0; i < nd_of(u); i++) b.push_back(d[i]);
    if (pm_of(u) != 0) b.push_back(pb);
    for (int i = 0; i < ns_of(u); i++) b.push_back(st[i]);
    fstart = cyc;
    for (int j = 0; j < b.size() * 16; j++) begin
      if (j == abort_at) begin
        rst_n = 1'b0;
        break;
      end
      rxd[u] = b[j / 16] ^ (j == glitch);
      if (rdy_at >= 0) rdy[u] = (j == rdy_at);
      tick(1);
    end
    if (rdy_at >= 0) rdy[u] = 1'b0;
    rxd[u] = idle_after;
  endtask

  task automatic frame_chk(input string tag, input int u,
                           input logic [8:0] d, input logic pb,
                           input logic [1:0] st, input int v0);
    chk({tag, "_data"}, 32'(data_of(u)), 32'(mask_of(u, d)));
    chk({tag, "_perr"}, 32'(pe[u]), 32'(model_pe(u, d, pb)));
    chk({tag, "_ferr"}, 32'(fe[u]), 32'(model_fe(u, st)));
    chk({tag, "_vpulse"}, 32'(vcnt[u] - v0), 32'd1);
    chk({tag, "_lat"}, 32'(rise[u]), 32'(exp_rise(u)));
  endtask

  initial begin
    int v0, o0;
    logic [8:0] d;
    logic pb;
    logic [1:0] st;

    for (int u = 0; u < 4; u++) begin
      rxd[u] = 1'b1;
      rdy[u] = 1'b1;
    end
    tick(3);
    for (int u = 0; u < 4; u++) begin
      chk("rst_valid", 32'(rv[u]), 32'd0);
      chk("rst_data", 32'(data_of(u)), 32'd0);
      chk("rst_flags", {29'd0, pe[u], fe[u], ov[u]}, 32'd0);
    end
    rst_n = 1'b1;
    tick(5);

    v0 = vcnt[0];
    send(0, 9'h0A5, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("8n1_a5", 0, 9'h0A5, 1'b0, 2'b11, v0);

    v0 = vcnt[1];
    send(1, 9'h003, 1'b1, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("even_bad", 1, 9'h003, 1'b1, 2'b11, v0);
    chk("even_bad_pe1", 32'(pe[1]), 32'd1);
    v0 = vcnt[1];
    send(1, 9'h003, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("even_good", 1, 9'h003, 1'b0, 2'b11, v0);
    v0 = vcnt[2];
    send(2, 9'h003, 1'b1, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("odd_good", 2, 9'h003, 1'b1, 2'b11, v0);
    chk("odd_good_pe0", 32'(pe[2]), 32'd0);

    v0 = vcnt[0];
    send(0, 9'h05A, 1'b0, 2'b00, -1, -1, -1, 1'b0);
    tick(40);
    frame_chk("break", 0, 9'h05A, 1'b0, 2'b00, v0);
    rxd[0] = 1'b1;
    tick(10);
    chk("break_nodup", 32'(vcnt[0] - v0), 32'd1);
    v0 = vcnt[0];
    send(0, 9'h0C3, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("after_break", 0, 9'h0C3, 1'b0, 2'b11, v0);

    v0 = vcnt[0];
    rxd[0] = 1'b0;
    tick(4);
    rxd[0] = 1'b1;
    tick(40);
    chk("glitch_start_nov", 32'(vcnt[0] - v0), 32'd0);
    send(0, 9'h03C, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("after_glitch", 0, 9'h03C, 1'b0, 2'b11, v0);

    v0 = vcnt[0];
    send(0, 9'h000, 1'b0, 2'b11, 16 * 3 + 9, -1, -1, 1'b1);
    tick(4);
    frame_chk("maj_vote", 0, 9'h000, 1'b0, 2'b11, v0);

    o0 = ocnt[0];
    rdy[0] = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    chk("ovr1_valid", 32'(rv[0]), 32'd1);
    chk("ovr1_data", 32'(d8[0]), 32'h11);
    send(0, 9'h022, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    chk("ovr2_data", 32'(d8[0]), 32'h11);
    chk("ovr2_pulse", 32'(ocnt[0] - o0), 32'd1);
    send(0, 9'h033, 1'b0, 2'b11, -1, 156, -1, 1'b1);
    tick(4);
    chk("ovr3_valid", 32'(rv[0]), 32'd1);
    chk("ovr3_data", 32'(d8[0]), 32'h33);
    chk("ovr3_noovr", 32'(ocnt[0] - o0), 32'd1);
    rdy[0] = 1'b1;
    tick(2);
    chk("ovr_drain", 32'(rv[0]), 32'd0);
    chk("ovr_hold", 32'(d8[0]), 32'h33);

    v0 = vcnt[3];
    send(3, 9'h1FF, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("9n2_1ff", 3, 9'h1FF, 1'b0, 2'b11, v0);
    v0 = vcnt[3];
    send(3, 9'h0AA, 1'b0, 2'b11, -1, -1, 16 * 4 + 5, 1'b1);
    #1;
    chk("mid_rst_valid", 32'(rv[3]), 32'd0);
    chk("mid_rst_data", 32'(d9), 32'd0);
    chk("mid_rst_flags", {29'd0, pe[3], fe[3], ov[3]}, 32'd0);
    tick(5);
    rst_n = 1'b1;
    tick(250);
    chk("mid_rst_nodeliv", 32'(vcnt[3] - v0), 32'd0);
    v0 = vcnt[3];
    send(3, 9'h155, 1'b0, 2'b11, -1, -1, -1, 1'b1);
    tick(4);
    frame_chk("9n2_155", 3, 9'h155, 1'b0, 2'b11, v0);

    for (int n = 0; n < 6; n++) begin
      for (int u = 0; u < 4; u++) begin
        d  = 9'($urandom);
        pb = good_pb(u, d) ^ ($urandom_range(0, 3) == 0);
        st = 2'b11;
        if ($urandom_range(0, 4) == 0)
          st = (ns_of(u) == 1) ? 2'b10 : 2'($urandom_range(0, 2));
        v0 = vcnt[u];
        send(u, d, pb, st, -1, -1, -1, 1'b1);
        tick(6);
        frame_chk($sformatf("rand_u%0d_n%0d", u, n), u, d, pb, st, v0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
